// File: rtl/if_id.sv
// IF/ID pipeline register for a 16-bit core: decouples the fetch side from decode
// with a one-entry skid buffer, stale-fetch discard after flush, and HALT capture.
module if_id (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc2_in,
  input  logic        imem_done,
  input  logic        imem_stall,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] pc2_out,
  output logic        valid_out,
  output logic        pc_hold,
  output logic        halted
);

  localparam logic [15:0] NOP     = 16'h0800;
  localparam logic [4:0]  HALT_OP = 5'b00000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t      state, state_d;

  logic [15:0] instr_d, pc2_d;
  logic        valid_d;
  logic [15:0] skid_instr, skid_pc2;
  logic [15:0] skid_instr_d, skid_pc2_d;
  logic        skid_full, skid_full_d;

  logic        fetching;
  logic [15:0] src_instr;
  logic        src_is_halt;

  // The skid entry always wins over the memory port; memory must be idle then.
  assign fetching    = (state == RUN) || (state == WAIT);
  assign src_instr   = skid_full ? skid_instr : instr_in;
  assign src_is_halt = (src_instr[15:11] == HALT_OP);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every comb output is given a default first, so no path infers a latch.
  always_comb begin
    state_d = state;
    if (flush) begin
      // A fetch still in flight belongs to the wrong path and must be dropped.
      state_d = ((state == WAIT) || (state == DISCARD)) ? DISCARD : RUN;
    end else if (stall) begin
      // The stale response is consumed even while decode holds the outputs.
      if ((state == DISCARD) && imem_done) state_d = RUN;
    end else if (skid_full) begin
      state_d = src_is_halt ? HALTED : RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (imem_done)       state_d = src_is_halt ? HALTED : RUN;
          else if (imem_stall) state_d = WAIT;
        end
        WAIT: begin
          if (imem_done) state_d = src_is_halt ? HALTED : RUN;
        end
        DISCARD: begin
          if (imem_done) state_d = RUN;
        end
        HALTED: state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / skid next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_d      = instr_out;
    pc2_d        = pc2_out;
    valid_d      = valid_out;
    skid_instr_d = skid_instr;
    skid_pc2_d   = skid_pc2;
    skid_full_d  = skid_full;

    if (flush) begin
      instr_d     = NOP;
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
    end else if (stall) begin
      if (imem_done && !skid_full && fetching) begin
        skid_instr_d = instr_in;
        skid_pc2_d   = pc2_in;
        skid_full_d  = 1'b1;
      end
    end else if (skid_full) begin
      instr_d     = skid_instr;
      pc2_d       = skid_pc2;
      valid_d     = 1'b1;
      skid_full_d = 1'b0;
    end else begin
      unique case (state)
        RUN, WAIT: begin
          if (imem_done) begin
            instr_d = instr_in;
            pc2_d   = pc2_in;
            valid_d = 1'b1;
          end else begin
            // Bubble keeps the last pc2 so ID_EX sees a stable value.
            instr_d = NOP;
            valid_d = 1'b0;
          end
        end
        DISCARD: begin
          instr_d = NOP;
          valid_d = 1'b0;
        end
        HALTED: valid_d = 1'b0;
        default: begin
          instr_d = NOP;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Flush does not hold the PC: the PC must take the branch target that cycle.
  assign pc_hold = stall | skid_full | (state != RUN) | (imem_stall & ~imem_done);
  assign halted  = (state == HALTED);

  // ---------------------------------------------------------------------------
  // Output and skid registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out <= NOP;
      pc2_out   <= 16'h0000;
      valid_out <= 1'b0;
      skid_full <= 1'b0;
    end else begin
      instr_out <= instr_d;
      pc2_out   <= pc2_d;
      valid_out <= valid_d;
      skid_full <= skid_full_d;
    end
  end

  // NOTE: skid payload is deliberately not reset; skid_full=0 masks it.
  always_ff @(posedge clk) begin
    skid_instr <= skid_instr_d;
    skid_pc2   <= skid_pc2_d;
  end

endmodule

// File: tb/tb_if_id.sv
// Directed self-checking bench for if_id: reset, fetch latency, memory wait,
// skid capture under stall, flush/discard, HALT capture and reset override.
module tb_if_id;

  logic        clk;
  logic        rst;
  logic [15:0] instr_in, pc2_in;
  logic        imem_done, imem_stall, stall, flush;
  logic [15:0] instr_out, pc2_out;
  logic        valid_out, pc_hold, halted;

  int checks   = 0;
  int failures = 0;

  if_id dut (
    .clk        (clk),
    .rst        (rst),
    .instr_in   (instr_in),
    .pc2_in     (pc2_in),
    .imem_done  (imem_done),
    .imem_stall (imem_stall),
    .stall      (stall),
    .flush      (flush),
    .instr_out  (instr_out),
    .pc2_out    (pc2_out),
    .valid_out  (valid_out),
    .pc_hold    (pc_hold),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic done, input logic istall, input logic st,
                       input logic fl, input logic [15:0] ins, input logic [15:0] pc2);
    imem_done  = done;
    imem_stall = istall;
    stall      = st;
    flush      = fl;
    instr_in   = ins;
    pc2_in     = pc2;
  endtask

  task automatic check_out(input string tag, input logic [15:0] ins,
                           input logic [15:0] pc2, input logic vld);
    check({tag, ".instr"}, instr_out, ins);
    check({tag, ".pc2"},   pc2_out,   pc2);
    check({tag, ".valid"}, {15'b0, valid_out}, {15'b0, vld});
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    step();
    rst = 1'b0;
    #1;
    check_out("reset", 16'h0800, 16'h0000, 1'b0);
    check("reset.halted",  {15'b0, halted},  16'h0000);
    check("reset.pc_hold", {15'b0, pc_hold}, 16'h0000);

    // Plain fetch, one-cycle latency
    drive(1, 0, 0, 0, 16'h4105, 16'h0002);
    step();
    check_out("fetch", 16'h4105, 16'h0002, 1'b1);

    // Memory wait for three cycles, then C0F0
    drive(0, 1, 0, 0, 16'hxxxx, 16'hxxxx);
    #1 check("wait.pc_hold0", {15'b0, pc_hold}, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("wait.bubble%0d", i), 16'h0800, 16'h0002, 1'b0);
      check($sformatf("wait.pc_hold%0d", i + 1), {15'b0, pc_hold}, 16'h0001);
    end
    drive(1, 0, 0, 0, 16'hC0F0, 16'h0004);
    step();
    check_out("wait.done", 16'hC0F0, 16'h0004, 1'b1);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    #1 check("wait.run_pc_hold", {15'b0, pc_hold}, 16'h0000);

    // Decode stall with a fetch completing: captured in the skid
    drive(1, 0, 1, 0, 16'hB2A0, 16'h0006);
    #1 check("skid.pc_hold_stall", {15'b0, pc_hold}, 16'h0001);
    step();
    check_out("skid.held", 16'hC0F0, 16'h0004, 1'b1);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    #1 check("skid.pc_hold_full", {15'b0, pc_hold}, 16'h0001);
    step();
    check_out("skid.unload", 16'hB2A0, 16'h0006, 1'b1);
    check("skid.pc_hold_clear", {15'b0, pc_hold}, 16'h0000);

    // Flush during WAIT: the stale 1234 response is dropped
    drive(0, 1, 0, 0, 16'h0000, 16'h0000);
    step();
    drive(0, 1, 0, 1, 16'h0000, 16'h0000);
    #1 check("disc.flush_pc_hold", {15'b0, pc_hold}, 16'h0001);
    step();
    check_out("disc.flush", 16'h0800, 16'h0006, 1'b0);
    drive(1, 0, 0, 0, 16'h1234, 16'h0008);
    step();
    check_out("disc.drop", 16'h0800, 16'h0006, 1'b0);
    drive(1, 0, 0, 0, 16'h5678, 16'h000A);
    step();
    check_out("disc.next", 16'h5678, 16'h000A, 1'b1);

    // HALT capture
    drive(1, 0, 0, 0, 16'h0000, 16'h000C);
    step();
    check_out("halt.load", 16'h0000, 16'h000C, 1'b1);
    check("halt.halted0", {15'b0, halted}, 16'h0001);
    drive(1, 0, 0, 0, 16'h4444, 16'h000E);
    step();
    check_out("halt.frozen", 16'h0000, 16'h000C, 1'b0);
    check("halt.halted1", {15'b0, halted},  16'h0001);
    check("halt.pc_hold", {15'b0, pc_hold}, 16'h0001);
    drive(0, 0, 0, 1, 16'h0000, 16'h0000);
    step();
    check_out("halt.flush", 16'h0800, 16'h000C, 1'b0);
    check("halt.released", {15'b0, halted}, 16'h0000);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    #1 check("halt.run_pc_hold", {15'b0, pc_hold}, 16'h0000);

    // Flush beats stall; a fetch in that cycle must not reach the skid
    drive(1, 0, 1, 1, 16'h7777, 16'h0010);
    step();
    check_out("fvs.flush", 16'h0800, 16'h000C, 1'b0);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    #1 check("fvs.no_skid", {15'b0, pc_hold}, 16'h0000);
    step();
    check_out("fvs.idle", 16'h0800, 16'h000C, 1'b0);

    // Reset mid-WAIT with a full skid
    drive(0, 1, 0, 0, 16'h0000, 16'h0000);
    step();
    drive(1, 0, 1, 0, 16'h9999, 16'h0012);
    step();
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    #1 check("rstw.pc_hold_full", {15'b0, pc_hold}, 16'h0001);
    rst = 1'b1;
    drive(1, 1, 1, 1, 16'h3333, 16'h0014);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    #1;
    check_out("rstw.reset", 16'h0800, 16'h0000, 1'b0);
    check("rstw.halted",  {15'b0, halted},  16'h0000);
    check("rstw.pc_hold", {15'b0, pc_hold}, 16'h0000);
    step();
    check_out("rstw.skid_empty", 16'h0800, 16'h0000, 1'b0);

    // Response right after reset is a fresh fetch, not discarded
    drive(1, 0, 0, 0, 16'h2222, 16'h0016);
    step();
    check_out("rstw.new_fetch", 16'h2222, 16'h0016, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_id.md
IF_ID -- requirements
Module: if_id

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset, one clock, applied at the clk edge.
REQ-002 SHALL have: instr_in  in  16  fetched instruction from instruction memory; pc2_in  in  16  PC+2 of the fetched instruction.
REQ-003 SHALL have: imem_done  in  1  fetch data valid this cycle; imem_stall  in  1  fetch still pending.
REQ-004 SHALL have: stall  in  1  hazard hold from decode; flush  in  1  taken branch/jump, discard the younger fetch.
REQ-005 SHALL have: instr_out  out  16  instruction to decode; pc2_out  out  16  PC+2 to ID_EX; valid_out  out  1  instr_out is real.
REQ-006 SHALL have: pc_hold  out  1  freeze PC register; halted  out  1  HALT captured, fetch stopped.
REQ-007 SHALL define NOP = 16'h0800 and HALT opcode = instr[15:11] == 5'b00000.

Function
REQ-008 SHALL implement FSM states RUN, WAIT, DISCARD, HALTED with a one-entry skid buffer (skid_instr, skid_pc2, skid_full).
REQ-009 SHALL apply per-edge priority: rst > flush > stall > fetch result.
REQ-010 In RUN with imem_done=1 and stall=0: load instr_in/pc2_in, valid_out=1, one-cycle latency; if the opcode is HALT, go to HALTED.
REQ-011 In RUN with imem_stall=1 and imem_done=0: load the bubble (instr_out=NOP, valid_out=0, pc2_out held) and go to WAIT.
REQ-012 In WAIT: bubble each cycle until imem_done; then behave as REQ-010 and return to RUN, or to HALTED on HALT.
REQ-013 stall=1: instr_out, pc2_out, valid_out and state held; an imem_done in the same cycle SHALL be written to the skid and set skid_full.
REQ-014 On the first cycle after stall drops with skid_full=1: outputs load from the skid, skid_full clears, and the HALT check applies to skid_instr.
REQ-015 SHALL drop imem_done while skid_full=1 (requester guarantees none, since pc_hold=1).
REQ-016 flush=1: load the bubble and clear skid_full; from WAIT go to DISCARD; from HALTED or RUN go to RUN.
REQ-017 flush overrides stall in the same cycle.
REQ-018 In DISCARD: drop the first imem_done (no output load) and go to RUN; a flush in DISCARD stays in DISCARD.
REQ-019 In HALTED: outputs frozen with the HALT instruction; after one valid cycle valid_out=0; leave only via flush or rst.
REQ-020 halted SHALL be 1 exactly when state==HALTED (registered).
REQ-021 pc_hold SHALL be combinational = stall | skid_full | (state!=RUN) | (imem_stall & ~imem_done).
REQ-022 flush SHALL not gate pc_hold, because the PC loads the branch target on flush.
REQ-023 pc2 SHALL pass through unmodified with no arithmetic; all widths are 16 bits.

Reset
REQ-024 rst=1 at an edge SHALL set instr_out=NOP, pc2_out=0, valid_out=0, skid_full=0, state=RUN, halted=0.
REQ-025 rst SHALL override flush, stall and an in-flight fetch; a pending memory response after reset is treated as new (no DISCARD).
REQ-026 Skid contents after reset SHALL be don't-care, gated by skid_full=0.

Verification
REQ-027 Reset, then imem_done=1, instr_in=16'h4105, pc2_in=16'h0002 -> next cycle instr_out=4105, pc2_out=0002, valid_out=1.
REQ-028 imem_stall=1 for 3 cycles then done with 16'hC0F0 -> 3 bubbles (0800, valid 0), pc_hold=1, then C0F0 valid; state returns to RUN.
REQ-029 stall=1 with imem_done=1, instr_in=16'hB2A0 -> outputs hold the previous value, pc_hold=1; stall drop -> B2A0 valid next cycle.
REQ-030 In WAIT, assert flush, then imem_done with 16'h1234 -> bubble, 1234 never appears; the next fetch 16'h5678 loads normally.
REQ-031 Fetch 16'h0000 -> valid one cycle, then halted=1 with the HALT held and valid 0; a flush returns to RUN with halted=0.
REQ-032 Assert rst mid-WAIT with skid_full=1 -> all outputs reset per REQ-024 on that edge.
